// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the multi-cycle multiply/divide unit.
// Optional feature macro: MULT_DIV_DIVZERO_EN (adds the DIVZ fast-exit state).
package mult_div_pkg;

  localparam int MD_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int MD_CNT_W = cnt_width(MD_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FINISH,
    DIVZ
  } state_t;

endpackage

// File: rtl/mult_div_datapath.sv
// Operand/accumulator registers with one radix-2 Booth or restoring-divide step per
// enabled cycle; the result outputs carry the final sign correction.
module mult_div_datapath
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_div,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic             r_is_div;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH:0]   r_m;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_abs_a = i_op_a[WIDTH-1] ? -i_op_a : i_op_a;
  assign w_abs_b = i_op_b[WIDTH-1] ? -i_op_b : i_op_b;

  // A is one bit wider than the operands so A - M cannot overflow for the most negative M.
  always_comb begin
    w_booth_sum = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_booth_sum = r_a + r_m;
      2'b10:   w_booth_sum = r_a - r_m;
      default: w_booth_sum = r_a;
    endcase
  end

  assign w_shift = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {1'b0, r_m};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_q      <= '0;
      r_q1     <= 1'b0;
      r_m      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_load) begin
      r_is_div <= i_div;
      r_a      <= '0;
      r_q1     <= 1'b0;
      if (i_div) begin
        r_q     <= w_abs_a;
        r_m     <= {1'b0, w_abs_b};
        r_neg_q <= i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1];
        r_neg_r <= i_op_a[WIDTH-1];
      end else begin
        r_q     <= i_op_b;
        r_m     <= {i_op_a[WIDTH-1], i_op_a};
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end
    end else if (i_step) begin
      if (r_is_div) begin
        if (w_diff[WIDTH+1]) begin
          r_a <= w_shift;
          r_q <= {r_q[WIDTH-2:0], 1'b0};
        end else begin
          r_a <= w_diff[WIDTH:0];
          r_q <= {r_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        r_a  <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        r_q  <= {w_booth_sum[0], r_q[WIDTH-1:1]};
        r_q1 <= r_q[0];
      end
    end
  end

  assign w_quot = r_neg_q ? -r_q : r_q;
  assign w_rem  = r_neg_r ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
  assign o_hi   = r_is_div ? w_rem  : r_a[WIDTH-1:0];
  assign o_lo   = r_is_div ? w_quot : r_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// Start/busy/done sequencer owning HI/LO for the iterative multiply/divide datapath.
// Define MULT_DIV_DIVZERO_EN to short-circuit divide-by-zero through the DIVZ state.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             flagMultStart,
  input  logic             flagDivStart,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             flagRegHighW,
  output logic             flagRegLowW,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             w_load;
  logic             w_load_div;
  logic             w_step;
  logic             w_commit;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Multiply has priority when both starts arrive in the same IDLE cycle.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_div   = 1'b0;
    w_step       = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (flagMultStart) begin
          w_state_next = MULT;
          w_load       = 1'b1;
        end else if (flagDivStart) begin
`ifdef MULT_DIV_DIVZERO_EN
          if (OpB == '0) begin
            w_state_next = DIVZ;
          end else begin
            w_state_next = DIV;
            w_load       = 1'b1;
            w_load_div   = 1'b1;
          end
`else
          w_state_next = DIV;
          w_load       = 1'b1;
          w_load_div   = 1'b1;
`endif
        end
      end
      MULT, DIV: begin
        if (r_cnt == LAST) begin
          w_state_next = FINISH;
          w_commit     = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end
      FINISH:  w_state_next = IDLE;
      DIVZ:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_load)      r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + CW'(1);
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  mult_div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_load (w_load),
    .i_div  (w_load_div),
    .i_step (w_step),
    .i_op_a (OpA),
    .i_op_b (OpB),
    .o_hi   (w_res_hi),
    .o_lo   (w_res_lo)
  );

  assign Busy         = (r_state != IDLE);
  assign Done         = (r_state == FINISH);
  assign flagRegHighW = (r_state == FINISH);
  assign flagRegLowW  = (r_state == FINISH);
`ifdef MULT_DIV_DIVZERO_EN
  assign DivZero      = (r_state == DIVZ);
`else
  assign DivZero      = 1'b0;
`endif
  assign Hi           = r_hi;
  assign Lo           = r_lo;

endmodule
